// File: rtl/seven_segment_scanner_if.sv
// Bundle of the display-driver signals between the register side and the pins.
//   master : drives value/dp/blank/lz_suppress/load/brightness, observes the pins
//   slave  : the scanner itself
// Valid/ready note: there is no back-pressure; load is a single-cycle strobe that is
// always accepted, and the last load before a frame boundary is the one displayed.
interface seven_segment_scanner_if #(
    parameter int DIGITS = 4,
    parameter int DIM_W  = 3
);
    localparam int IDX_W = $clog2(DIGITS);

    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lz_suppress;
    logic                load;
    logic [DIM_W-1:0]    brightness;
    logic [DIGITS-1:0]   an;
    logic [7:0]          pattern;
    logic [IDX_W-1:0]    digit_idx;
    logic                frame_done;

    modport master (
        output value, dp, blank, lz_suppress, load, brightness,
        input  an, pattern, digit_idx, frame_done
    );

    modport slave (
        input  value, dp, blank, lz_suppress, load, brightness,
        output an, pattern, digit_idx, frame_done
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment driver with double-buffered frame data.
//   clk    : system clock
//   reset  : asynchronous, active-high
//   bus    : slave modport carrying value/dp/blank/lz_suppress/load/brightness in,
//            an/pattern/digit_idx/frame_done out
// A free-running prescaler defines one digit slot per 2**PRESCALE_W clocks. Staged data
// moves into the active buffer only at the frame boundary, so a frame never mixes two
// loads. an/pattern are registered (one cycle behind count/digit_idx).
module seven_segment_scanner #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE_W     = 17,
    parameter int DIM_W          = 3,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    seven_segment_scanner_if.slave  bus
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    // Pin levels meaning "off"; XOR with these converts active-high to pin polarity.
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [PRESCALE_W-1:0] count_q, count_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   stg_value_q, stg_value_d, act_value_q, act_value_d;
    logic [DIGITS-1:0]     stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]     stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
    logic                  stg_lz_q, stg_lz_d, act_lz_q, act_lz_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [7:0]            pattern_q, pattern_d;

    logic                  terminal;
    logic                  boundary;

    // Prescaler, digit sequencing and buffer management.
    always_comb begin
        terminal     = (count_q == {PRESCALE_W{1'b1}});
        boundary     = terminal && (idx_q == LAST_IDX);
        count_d      = count_q + PRESCALE_W'(1);
        idx_d        = idx_q;
        frame_done_d = boundary;
        stg_value_d  = stg_value_q;
        stg_dp_d     = stg_dp_q;
        stg_blank_d  = stg_blank_q;
        stg_lz_d     = stg_lz_q;
        pending_d    = pending_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        act_lz_d     = act_lz_q;

        if (terminal) begin
            idx_d = boundary ? '0 : idx_q + IDX_W'(1);
        end

        if (bus.load) begin
            stg_value_d = bus.value;
            stg_dp_d    = bus.dp;
            stg_blank_d = bus.blank;
            stg_lz_d    = bus.lz_suppress;
            pending_d   = 1'b1;
        end

        if (boundary) begin
            // A load landing on the boundary bypasses staging and wins over older staged data.
            if (bus.load) begin
                act_value_d = bus.value;
                act_dp_d    = bus.dp;
                act_blank_d = bus.blank;
                act_lz_d    = bus.lz_suppress;
            end else if (pending_q) begin
                act_value_d = stg_value_q;
                act_dp_d    = stg_dp_q;
                act_blank_d = stg_blank_q;
                act_lz_d    = stg_lz_q;
            end
            pending_d = 1'b0;
        end
    end

    logic [DIGITS-1:0] supp;
    logic              zero_run;
    logic [3:0]        nib;
    logic [6:0]        seg7;
    logic              digit_on;
    logic              bright_on;
    logic [DIGITS-1:0] an_hi;
    logic [7:0]        pat_hi;

    // Pin pattern for the current slot, computed in active-high form first.
    always_comb begin
        // Walk down from the top digit; the run of zeros ends at the first nonzero nibble.
        supp     = '0;
        zero_run = act_lz_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (act_value_q[4*i +: 4] == 4'h0);
            supp[i]  = zero_run;
        end

        nib = act_value_q[{idx_q, 2'b00} +: 4];
        case (nib)
            4'h0: seg7 = 7'h7E;
            4'h1: seg7 = 7'h30;
            4'h2: seg7 = 7'h6D;
            4'h3: seg7 = 7'h79;
            4'h4: seg7 = 7'h33;
            4'h5: seg7 = 7'h5B;
            4'h6: seg7 = 7'h5F;
            4'h7: seg7 = 7'h70;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h73;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h1F;
            4'hC: seg7 = 7'h4E;
            4'hD: seg7 = 7'h3D;
            4'hE: seg7 = 7'h4F;
            default: seg7 = 7'h47;
        endcase

        digit_on  = !act_blank_q[idx_q] && !supp[idx_q];
        bright_on = (count_q[PRESCALE_W-1 -: DIM_W] <= bus.brightness);

        an_hi = '0;
        if (digit_on && bright_on) begin
            an_hi[idx_q] = 1'b1;
        end
        pat_hi = digit_on ? {act_dp_q[idx_q], seg7} : 8'h00;

        an_d      = an_hi ^ AN_OFF;
        pattern_d = pat_hi ^ SEG_OFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            idx_q        <= '0;
            stg_value_q  <= '0;
            stg_dp_q     <= '0;
            stg_blank_q  <= '0;
            stg_lz_q     <= 1'b0;
            pending_q    <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            act_lz_q     <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            pattern_q    <= SEG_OFF;
        end else begin
            count_q      <= count_d;
            idx_q        <= idx_d;
            stg_value_q  <= stg_value_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            stg_lz_q     <= stg_lz_d;
            pending_q    <= pending_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_lz_q     <= act_lz_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            pattern_q    <= pattern_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.pattern    = pattern_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner with DIGITS=4, PRESCALE_W=4, DIM_W=2, active-low pins.
// Each frame's expected pin values {an, pattern, digit_idx, frame_done} are queued when the
// frame's data and brightness are set up, then popped one per cycle on the falling edge.
module tb_seven_segment_scanner;
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
    } disp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [14:0] exp_q[$];

    seven_segment_scanner_if #(.DIGITS(4), .DIM_W(2)) bus ();

    seven_segment_scanner #(
        .DIGITS(4), .PRESCALE_W(4), .DIM_W(2), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t[16];
        t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return t[n];
    endfunction

    // Expected pins at cycle j (0..63) of a frame showing d.
    function automatic logic [14:0] exp_pins(input disp_t d, input logic [1:0] br, input int j);
        int         cnt;
        int         idx;
        int         nxt_idx;
        logic [3:0] nib;
        logic [3:0] an;
        logic [7:0] pat;
        logic       sup;
        logic       on;
        cnt     = j % 16;
        idx     = j / 16;
        nxt_idx = ((j + 1) / 16) % 4;
        nib     = d.value[4*idx +: 4];
        // Suppressed when every nibble from this digit upward is zero.
        sup     = d.lz && (idx > 0) && ((d.value >> (4 * idx)) == 16'h0);
        on      = !d.blank[idx] && !sup;
        an      = 4'hF;
        if (on && ((cnt / 4) <= int'(br))) an[idx] = 1'b0;
        pat     = on ? ~{d.dp[idx], seg_of(nib)} : 8'hFF;
        return {an, pat, 2'(nxt_idx), (j == 63)};
    endfunction

    task automatic chk(input string tag, input int j, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s j=%0d observed=%h expected=%h", tag, j, obs, expv);
        end
    endtask

    // Driver tasks
    task automatic drive(input disp_t d);
        bus.value       = d.value;
        bus.dp          = d.dp;
        bus.blank       = d.blank;
        bus.lz_suppress = d.lz;
    endtask

    task automatic scramble();
        bus.value       = 16'($urandom_range(0, 65535));
        bus.dp          = 4'($urandom_range(0, 15));
        bus.blank       = 4'($urandom_range(0, 15));
        bus.lz_suppress = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_an"},   0, 16'(bus.an),         16'h000F);
        chk({tag, "_pat"},  0, 16'(bus.pattern),    16'h00FF);
        chk({tag, "_idx"},  0, 16'(bus.digit_idx),  16'h0000);
        chk({tag, "_done"}, 0, 16'(bus.frame_done), 16'h0000);
    endtask

    // Called at the falling edge right after a frame boundary (or right after reset release).
    // Optional loads at cycles lj1/lj2 (-1 = none); nxt is what the following frame shows.
    task automatic check_frame(input string tag, input disp_t cur, input logic [1:0] br,
                               input int lj1, input disp_t d1, input int lj2, input disp_t d2,
                               output disp_t nxt);
        logic [14:0] e;
        logic [14:0] obs;
        bus.brightness = br;
        for (int j = 0; j < 64; j++) exp_q.push_back(exp_pins(cur, br, j));
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            obs = {bus.an, bus.pattern, bus.digit_idx, bus.frame_done};
            if (exp_q.size() == 0) begin
                chk({tag, "_qempty"}, j, 16'(obs), 16'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk(tag, j, 16'(obs), 16'(e));
            end
            if (j == lj1) begin
                drive(d1);
                bus.load = 1'b1;
            end else if (j == lj2) begin
                drive(d2);
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
                scramble();
            end
        end
        bus.load = 1'b0;
        nxt = (lj2 >= 0) ? d2 : ((lj1 >= 0) ? d1 : cur);
    endtask

    initial begin
        disp_t z, a, b, x, l, zl, p, q, r, cur, nxt;
        n_tests = 0;
        n_fail  = 0;
        z  = '{value: 16'h0000, dp: 4'b0000, blank: 4'b0000, lz: 1'b0};
        a  = '{value: 16'h12AF, dp: 4'b0000, blank: 4'b0000, lz: 1'b0};
        b  = '{value: 16'h3C5E, dp: 4'b1010, blank: 4'b0000, lz: 1'b0};
        x  = '{value: 16'h9999, dp: 4'b1111, blank: 4'b0000, lz: 1'b0};
        l  = '{value: 16'h0050, dp: 4'b0000, blank: 4'b0000, lz: 1'b1};
        zl = '{value: 16'h0000, dp: 4'b0000, blank: 4'b0000, lz: 1'b1};
        p  = '{value: 16'h8E47, dp: 4'b0000, blank: 4'b0000, lz: 1'b0};
        q  = '{value: 16'h6B0D, dp: 4'b0001, blank: 4'b0100, lz: 1'b0};
        r  = '{value: 16'hD00B, dp: 4'b1111, blank: 4'b0000, lz: 1'b0};

        reset          = 1'b1;
        bus.load       = 1'b0;
        bus.brightness = 2'd3;
        drive(z);
        repeat (2) @(negedge clk);
        check_reset("reset");
        reset = 1'b0;

        // Post-reset frame shows 0000; 12AF loaded mid-frame.
        check_frame("f0_zero", z, 2'd3, 10, a, -1, z, cur);
        // 12AF shown; load at cycle 5 must not tear this frame.
        check_frame("f1_12af", cur, 2'd3, 5, b, -1, z, nxt);
        cur = nxt;
        // Two loads: the one on the boundary cycle wins.
        check_frame("f2_3c5e", cur, 2'd3, 20, x, 62, l, nxt);
        cur = nxt;
        check_frame("f3_lz0050", cur, 2'd3, 30, zl, -1, z, nxt);
        cur = nxt;
        check_frame("f4_lz0000_br0", cur, 2'd0, 7, p, -1, z, nxt);
        cur = nxt;
        check_frame("f5_br1", cur, 2'd1, 9, q, -1, z, nxt);
        cur = nxt;
        check_frame("f6_blank_dp", cur, 2'd2, -1, z, -1, z, nxt);
        cur = nxt;

        // Stage data, then reset mid-slot: staged data must be discarded.
        bus.brightness = 2'd3;
        drive(r);
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset("midreset");
        @(negedge clk);
        reset = 1'b0;
        check_frame("f7_after_reset", z, 2'd3, -1, z, -1, z, nxt);
        check_frame("f8_still_zero", nxt, 2'd3, -1, z, -1, z, cur);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
